// File: rtl/upd0_fifo_pkg.sv
// Shared definitions for the two_one FIFO family (up and down converters).
// Provides pop-request encodings and the pointer-width helper.
package fifo_pkg;

   localparam logic [1:0] POP_NONE = 2'b00;
   localparam logic [1:0] POP_ONE  = 2'b01;
   localparam logic [1:0] POP_TWO  = 2'b10;

   // Pointer width for a power-of-two depth; never narrower than 1 bit.
   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/upd0_fifo_mem.sv
// Narrow-word register file: one write port, two async read ports at addr and addr+1.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata0_o (addr), rdata1_o (addr+1).
module upd0_fifo_mem #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SIZE  = 32,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata0_o,
   output logic [WIDTH-1:0] rdata1_o
);

   logic [WIDTH-1:0] mem_q [SIZE];
   logic [AW-1:0]    raddr1;

   // Second read address wraps naturally at the pointer width.
   assign raddr1 = raddr_i + 1'b1;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata0_o = mem_q[raddr_i];
   assign rdata1_o = mem_q[raddr1];

endmodule

// File: rtl/upd0_fifo.sv
// Up-converting FIFO: one narrow word per push, one or two words per pop into 2*WIDTH rdata.
// Ports: clk, rst_n (sync low), push, pop[1:0], wdata -> rdata, full, empty, al_full, al_empty, ack, valid.
module upd0_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned SIZE     = 32,
   parameter bit          FULL     = 1'b1,
   parameter bit          EMPTY    = 1'b1,
   parameter int unsigned AL_FULL  = 2,
   parameter int unsigned AL_EMPTY = 2,
   parameter bit          ACK      = 1'b1,
   parameter bit          VALID    = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [1:0]         pop,
   input  logic [WIDTH-1:0]   wdata,
   output logic [2*WIDTH-1:0] rdata,
   output logic               full,
   output logic [1:0]         empty,
   output logic               al_full,
   output logic [1:0]         al_empty,
   output logic               ack,
   output logic               valid
);

   localparam int PW = ptr_w(SIZE);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
   localparam logic [CW-1:0] AF_C   = CW'(SIZE - AL_FULL);
   localparam logic [CW-1:0] AE0_C  = CW'(AL_EMPTY);
   localparam logic [CW-1:0] AE1_C  = CW'(AL_EMPTY + 1);

   logic [PW-1:0]      wptr_q, wptr_d;
   logic [PW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] rdata_q, rdata_d;
   logic               ack_q, valid_q;

   logic [1:0]         pop_n;
   logic               push_acc;
   logic               pop_acc;
   logic [WIDTH-1:0]   rd0, rd1;
   logic [CW-1:0]      inc_w, dec_w;

   // pop[1] takes precedence, so 2'b11 is a pop-two request.
   always_comb begin
      pop_n = 2'd0;
      unique case (1'b1)
         pop[1]:            pop_n = 2'd2;
         (pop == POP_ONE):  pop_n = 2'd1;
         default:           pop_n = 2'd0;
      endcase
   end

   // Acceptance uses only the registered count: no same-cycle bypass.
   assign push_acc = push && (count_q < SIZE_C);
   assign pop_acc  = (pop_n != 2'd0) && (count_q >= CW'(pop_n));

   assign inc_w = CW'(push_acc);
   assign dec_w = pop_acc ? CW'(pop_n) : '0;

   upd0_fifo_mem #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .AW    (PW)
   ) u_mem (
      .clk      (clk),
      .we_i     (push_acc),
      .waddr_i  (wptr_q),
      .wdata_i  (wdata),
      .raddr_i  (rptr_q),
      .rdata0_o (rd0),
      .rdata1_o (rd1)
   );

   always_comb begin
      wptr_d  = wptr_q + PW'(push_acc);
      rptr_d  = rptr_q;
      rdata_d = rdata_q;
      count_d = count_q + inc_w - dec_w;
      if (pop_acc) begin
         rptr_d = rptr_q + PW'(pop_n);
         if (pop_n == 2'd2) begin
            rdata_d = {rd1, rd0};
         end else begin
            rdata_d = {{WIDTH{1'b0}}, rd0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
         ack_q   <= ACK && push_acc;
         valid_q <= VALID && pop_acc;
      end
   end

   assign rdata    = rdata_q;
   assign ack      = ack_q;
   assign valid    = valid_q;
   assign full     = FULL  ? (count_q == SIZE_C) : 1'b0;
   assign empty    = EMPTY ? {count_q < CW'(2), count_q == '0} : 2'b00;
   assign al_full  = (count_q >= AF_C);
   assign al_empty = {count_q <= AE1_C, count_q <= AE0_C};

endmodule

// File: tb/tb_upd0_fifo.sv
// Directed self-checking bench for upd0_fifo (WIDTH=16, SIZE=8, margins 2).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_upd0_fifo;

   logic        clk;
   logic        rst_n;
   logic        push;
   logic [1:0]  pop;
   logic [15:0] wdata;
   logic [31:0] rdata;
   logic        full;
   logic [1:0]  empty;
   logic        al_full;
   logic [1:0]  al_empty;
   logic        ack;
   logic        valid;

   int checks = 0;
   int errors = 0;

   upd0_fifo #(
      .WIDTH    (16),
      .SIZE     (8),
      .FULL     (1'b1),
      .EMPTY    (1'b1),
      .AL_FULL  (2),
      .AL_EMPTY (2),
      .ACK      (1'b1),
      .VALID    (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .wdata    (wdata),
      .rdata    (rdata),
      .full     (full),
      .empty    (empty),
      .al_full  (al_full),
      .al_empty (al_empty),
      .ack      (ack),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic [15:0] d, input logic [1:0] pp);
      push  = p;
      wdata = d;
      pop   = pp;
      tick();
      push  = 1'b0;
      pop   = 2'b00;
   endtask

   task automatic check_reset_state(input string tag);
      checks++;
      if (full !== 1'b0 || empty !== 2'b11 || al_empty !== 2'b11 || al_full !== 1'b0 ||
          rdata !== 32'h0 || ack !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL %s got full=%b empty=%b ale=%b alf=%b rdata=%h ack=%b valid=%b exp 0 11 11 0 0 0 0",
                  tag, full, empty, al_empty, al_full, rdata, ack, valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      push  = 1'b0;
      pop   = 2'b00;
      wdata = '0;
      tick();
      tick();
      check_reset_state("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [15:0] w [3];
      w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, w[i], 2'b00);
         checks++;
         if (ack !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack%0d got %b exp 1", i, ack);
         end
      end
      drive(1'b0, '0, 2'b10);
      checks++;
      if (rdata !== 32'h2222_1111 || valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_pop2 got %h/%b exp 22221111/1", rdata, valid);
      end
      drive(1'b0, '0, 2'b01);
      checks++;
      if (rdata !== 32'h0000_3333 || valid !== 1'b1 || empty !== 2'b11) begin
         errors++;
         $display("FAIL basic_pop1 got %h/%b/%b exp 00003333/1/11", rdata, valid, empty);
      end
      drive(1'b0, '0, 2'b00);
      checks++;
      if (rdata !== 32'h0000_3333 || valid !== 1'b0 || ack !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle got %h/%b/%b exp 00003333/0/0", rdata, valid, ack);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'h0100 + 16'(i), 2'b00);
         checks++;
         if (ack !== 1'b1 || al_full !== (i + 1 >= 6) || full !== (i + 1 == 8)) begin
            errors++;
            $display("FAIL full_fill%0d got ack=%b alf=%b full=%b exp 1/%b/%b",
                     i, ack, al_full, full, (i + 1 >= 6), (i + 1 == 8));
         end
      end
      drive(1'b1, 16'hDEAD, 2'b00);
      checks++;
      if (ack !== 1'b0 || full !== 1'b1) begin
         errors++;
         $display("FAIL full_ovf got ack=%b full=%b exp 0/1", ack, full);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, '0, 2'b10);
         checks++;
         if (valid !== 1'b1 ||
             rdata !== {16'h0101 + 16'(2 * k), 16'h0100 + 16'(2 * k)}) begin
            errors++;
            $display("FAIL full_drain%0d got %h/%b exp %h/1", k, rdata, valid,
                     {16'h0101 + 16'(2 * k), 16'h0100 + 16'(2 * k)});
         end
      end
      checks++;
      if (empty !== 2'b11 || full !== 1'b0) begin
         errors++;
         $display("FAIL full_empty got %b/%b exp 11/0", empty, full);
      end
   endtask

   task automatic test_reject();
      drive(1'b1, 16'h0055, 2'b00);
      drive(1'b0, '0, 2'b10);
      checks++;
      if (valid !== 1'b0 || rdata !== 32'h0107_0106 || empty !== 2'b10) begin
         errors++;
         $display("FAIL reject_pop2 got %b/%h/%b exp 0/01070106/10", valid, rdata, empty);
      end
      drive(1'b0, '0, 2'b11);
      checks++;
      if (valid !== 1'b0 || rdata !== 32'h0107_0106 || empty !== 2'b10) begin
         errors++;
         $display("FAIL reject_pop11 got %b/%h/%b exp 0/01070106/10", valid, rdata, empty);
      end
      drive(1'b0, '0, 2'b01);
      checks++;
      if (valid !== 1'b1 || rdata !== 32'h0000_0055 || empty !== 2'b11) begin
         errors++;
         $display("FAIL reject_pop1 got %b/%h/%b exp 1/00000055/11", valid, rdata, empty);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp [4];
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) drive(1'b1, 16'(i), 2'b00);
      for (int k = 0; k < 3; k++) drive(1'b0, '0, 2'b10);
      for (int i = 10; i <= 15; i++) drive(1'b1, 16'(i), 2'b00);
      // rptr=6: pop one first so the next pop-two starts at rptr=7.
      exp[0] = 32'h0000_0007;
      exp[1] = 32'h000B_000A;
      exp[2] = 32'h000D_000C;
      exp[3] = 32'h000F_000E;
      drive(1'b0, '0, 2'b01);
      checks++;
      if (rdata !== exp[0] || valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pop1 got %h/%b exp %h/1", rdata, valid, exp[0]);
      end
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, '0, 2'b10);
         checks++;
         if (rdata !== exp[k] || valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pop2_%0d got %h/%b exp %h/1", k, rdata, valid, exp[k]);
         end
      end
      checks++;
      if (empty !== 2'b11) begin
         errors++;
         $display("FAIL wrap_empty got %b exp 11", empty);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h0021 + 16'(i), 2'b00);
      drive(1'b1, 16'h0024, 2'b01);
      checks++;
      if (ack !== 1'b1 || valid !== 1'b1 || rdata !== 32'h0000_0021 ||
          empty !== 2'b00 || al_empty !== 2'b10) begin
         errors++;
         $display("FAIL b2b_pp1 got %b/%b/%h/%b/%b exp 1/1/00000021/00/10",
                  ack, valid, rdata, empty, al_empty);
      end
      for (int i = 0; i < 5; i++) drive(1'b1, 16'h0025 + 16'(i), 2'b00);
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL b2b_full got %b exp 1", full);
      end
      drive(1'b1, 16'h002A, 2'b10);
      checks++;
      if (ack !== 1'b0 || valid !== 1'b1 || rdata !== 32'h0023_0022 ||
          full !== 1'b0 || al_full !== 1'b1 || empty !== 2'b00) begin
         errors++;
         $display("FAIL b2b_pp2 got %b/%b/%h/%b/%b/%b exp 0/1/00230022/0/1/00",
                  ack, valid, rdata, full, al_full, empty);
      end
      rst_n = 1'b0;
      push  = 1'b1;
      pop   = 2'b10;
      tick();
      push  = 1'b0;
      pop   = 2'b00;
      check_reset_state("b2b_midreset");
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_reject();
      test_wrap();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
